// File: rtl/i2s_audio_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_audio_tx
// Brief    : I2S transmitter with sample-pair FIFO, mclk/sclk/lrck generation
//            and one-bit-delayed MSB-first serial data.
//            Optional macro I2S_TX_UNDERRUN_HOLD_EN: repeat last pair on underrun
//            (default build plays silence).
// Revision : 1.0 - initial release
// ============================================================================
module i2s_audio_tx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_BITS    = 32,
    parameter int MCLK_DIV     = 4,
    parameter int BCLK_DIV     = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int STEREO       = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [SAMPLE_WIDTH-1:0]         sample_l,
    input  logic [SAMPLE_WIDTH-1:0]         sample_r,
    input  logic                            sample_valid,
    output logic                            sample_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            underrun,
    output logic                            mclk,
    output logic                            sclk,
    output logic                            lrck,
    output logic                            dac
);

    localparam int c_PH_W    = $clog2(BCLK_DIV);
    localparam int c_MC_W    = $clog2(MCLK_DIV);
    localparam int c_BIT_W   = $clog2(2*SLOT_BITS);
    localparam int c_LVL_W   = $clog2(FIFO_DEPTH+1);
    localparam int c_AW      = $clog2(FIFO_DEPTH);
    localparam int c_ENTRY_W = (STEREO != 0) ? 2*SAMPLE_WIDTH : SAMPLE_WIDTH;
    localparam int c_EXT_W   = 2**c_BIT_W;

    localparam logic [c_PH_W-1:0]  c_PH_LAST  = c_PH_W'(BCLK_DIV-1);
    localparam logic [c_PH_W-1:0]  c_PH_HALF  = c_PH_W'(BCLK_DIV/2);
    localparam logic [c_MC_W-1:0]  c_MC_LAST  = c_MC_W'(MCLK_DIV-1);
    localparam logic [c_MC_W-1:0]  c_MC_HALF  = c_MC_W'(MCLK_DIV/2);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(2*SLOT_BITS-1);
    localparam logic [c_BIT_W-1:0] c_SLOT     = c_BIT_W'(SLOT_BITS);
    localparam logic [c_BIT_W-1:0] c_SW       = c_BIT_W'(SAMPLE_WIDTH);
    localparam logic [c_LVL_W-1:0] c_FULL     = c_LVL_W'(FIFO_DEPTH);

    logic [c_PH_W-1:0]       r_phase, w_phase_nxt;
    logic [c_MC_W-1:0]       r_mc, w_mc_nxt;
    logic [c_BIT_W-1:0]      r_bit_idx, w_bit_nxt;
    logic                    w_phase_wrap, w_boundary;
    logic                    r_mclk, r_sclk, r_lrck, r_dac, r_underrun, r_ready;

    logic [c_ENTRY_W-1:0]    r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [c_LVL_W-1:0]      r_level, w_level_nxt;
    logic [c_ENTRY_W-1:0]    w_wr_data, w_head;
    logic [SAMPLE_WIDTH-1:0] w_head_l, w_head_r;
    logic                    w_push, w_pop;

    logic [SAMPLE_WIDTH-1:0] r_frame_l, r_frame_r, w_slot_sample;
    logic [c_BIT_W-1:0]      w_k, w_idx;
    logic [c_EXT_W-1:0]      w_ext;
    logic                    w_dac_nxt;

    // Timebase
    assign w_phase_wrap = (r_phase == c_PH_LAST);
    assign w_phase_nxt  = w_phase_wrap ? '0 : r_phase + 1'b1;
    assign w_mc_nxt     = (r_mc == c_MC_LAST) ? '0 : r_mc + 1'b1;
    assign w_bit_nxt    = !w_phase_wrap ? r_bit_idx :
                          ((r_bit_idx == c_BIT_LAST) ? '0 : r_bit_idx + 1'b1);
    assign w_boundary   = w_phase_wrap && (r_bit_idx == c_BIT_LAST);

    // Serial bit for the slot position being entered on the next sclk fall
    assign w_k           = (w_bit_nxt >= c_SLOT) ? w_bit_nxt - c_SLOT : w_bit_nxt;
    assign w_slot_sample = (w_bit_nxt >= c_SLOT) ? r_frame_r : r_frame_l;
    assign w_ext         = c_EXT_W'(w_slot_sample);
    assign w_idx         = c_SW - w_k;
    assign w_dac_nxt     = (w_k != '0) && (w_k <= c_SW) && w_ext[w_idx];

    // FIFO
    assign w_push = sample_valid && r_ready;
    assign w_pop  = w_boundary && (r_level != '0);
    assign w_head = r_mem[r_rd_ptr];

    generate
        if (STEREO != 0) begin : g_stereo
            assign w_wr_data = {sample_l, sample_r};
            assign w_head_l  = w_head[c_ENTRY_W-1 -: SAMPLE_WIDTH];
            assign w_head_r  = w_head[SAMPLE_WIDTH-1:0];
        end else begin : g_mono
            logic w_unused_r;
            assign w_unused_r = ^sample_r;
            assign w_wr_data  = sample_l;
            assign w_head_l   = w_head;
            assign w_head_r   = w_head;
        end
    endgenerate

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop)
            w_level_nxt = r_level + 1'b1;
        else if (!w_push && w_pop)
            w_level_nxt = r_level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase    <= '0;
            r_mc       <= '0;
            r_bit_idx  <= '0;
            r_mclk     <= 1'b0;
            r_sclk     <= 1'b0;
            r_lrck     <= 1'b0;
            r_dac      <= 1'b0;
            r_underrun <= 1'b0;
            r_ready    <= 1'b0;
            r_level    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_frame_l  <= '0;
            r_frame_r  <= '0;
        end else begin
            r_phase    <= w_phase_nxt;
            r_mc       <= w_mc_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_mclk     <= (w_mc_nxt >= c_MC_HALF);
            r_sclk     <= (w_phase_nxt >= c_PH_HALF);
            r_lrck     <= (w_bit_nxt >= c_SLOT);
            r_underrun <= w_boundary && (r_level == '0);
            r_level    <= w_level_nxt;
            r_ready    <= (w_level_nxt != c_FULL);
            if (w_phase_wrap)
                r_dac <= w_dac_nxt;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_boundary) begin
                if (w_pop) begin
                    r_frame_l <= w_head_l;
                    r_frame_r <= w_head_r;
                end else begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
                    r_frame_l <= r_frame_l;
                    r_frame_r <= r_frame_r;
`else
                    r_frame_l <= '0;
                    r_frame_r <= '0;
`endif
                end
            end
        end
    end

    assign sample_ready = r_ready;
    assign fifo_level   = r_level;
    assign underrun     = r_underrun;
    assign mclk         = r_mclk;
    assign sclk         = r_sclk;
    assign lrck         = r_lrck;
    assign dac          = r_dac;

endmodule
`default_nettype wire

// File: tb/tb_i2s_audio_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_audio_tx
// Brief    : Bench for i2s_audio_tx (stereo and mono instances) against a
//            frame-level reference model built from cycle-time arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_audio_tx;

    localparam int SW    = 16;
    localparam int SLOT  = 32;
    localparam int MDIV  = 4;
    localparam int BDIV  = 16;
    localparam int DEPTH = 4;
    localparam int FRAME = 2*SLOT*BDIV;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
    localparam bit c_HOLD = 1'b1;
`else
    localparam bit c_HOLD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] sample_l, sample_r;
    logic          sample_valid;
    logic          sample_ready, underrun, mclk, sclk, lrck, dac;
    logic [2:0]    fifo_level;
    logic          sample_ready_m, underrun_m, mclk_m, sclk_m, lrck_m, dac_m;
    logic [2:0]    fifo_level_m;

    always #5 clk = ~clk;

    i2s_audio_tx #(.SAMPLE_WIDTH(SW), .SLOT_BITS(SLOT), .MCLK_DIV(MDIV),
                   .BCLK_DIV(BDIV), .FIFO_DEPTH(DEPTH), .STEREO(1)) u_dut (
        .clk(clk), .reset(reset), .sample_l(sample_l), .sample_r(sample_r),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .fifo_level(fifo_level), .underrun(underrun), .mclk(mclk),
        .sclk(sclk), .lrck(lrck), .dac(dac));

    i2s_audio_tx #(.SAMPLE_WIDTH(SW), .SLOT_BITS(SLOT), .MCLK_DIV(MDIV),
                   .BCLK_DIV(BDIV), .FIFO_DEPTH(DEPTH), .STEREO(0)) u_dut_mono (
        .clk(clk), .reset(reset), .sample_l(sample_l), .sample_r(sample_r),
        .sample_valid(sample_valid), .sample_ready(sample_ready_m),
        .fifo_level(fifo_level_m), .underrun(underrun_m), .mclk(mclk_m),
        .sclk(sclk_m), .lrck(lrck_m), .dac(dac_m));

    // Reference model: cycles since reset, queued pairs, pair playing now
    int            t;
    logic [31:0]   q[$];
    logic [SW-1:0] cur_l, cur_r;
    bit            exp_und;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic exp_dac(input int tt, input logic [SW-1:0] l, input logic [SW-1:0] r);
        int            b;
        int            k;
        logic [SW-1:0] s;
        b = (tt % FRAME) / BDIV;
        k = b % SLOT;
        s = (b >= SLOT) ? r : l;
        if (k >= 1 && k <= SW)
            return s[SW-k];
        return 1'b0;
    endfunction

    task automatic check_all();
        logic exp_rdy;
        exp_rdy = (t > 0) && (q.size() != DEPTH);
        check("mclk",     mclk,   32'((t % MDIV) >= MDIV/2));
        check("sclk",     sclk,   32'((t % BDIV) >= BDIV/2));
        check("lrck",     lrck,   32'(((t % FRAME) / BDIV) >= SLOT));
        check("dac",      dac,    32'(exp_dac(t, cur_l, cur_r)));
        check("dac_mono", dac_m,  32'(exp_dac(t, cur_l, cur_l)));
        check("underrun", underrun,   32'(exp_und));
        check("und_mono", underrun_m, 32'(exp_und));
        check("level",    fifo_level,   q.size());
        check("lvl_mono", fifo_level_m, q.size());
        check("ready",    sample_ready,   32'(exp_rdy));
        check("rdy_mono", sample_ready_m, 32'(exp_rdy));
    endtask

    // One clock: drive inputs, advance the model across the edge, check
    task automatic cycle(input bit v, input logic [SW-1:0] l, input logic [SW-1:0] r);
        bit          push, bnd;
        logic [31:0] e;
        sample_valid = v;
        sample_l     = l;
        sample_r     = r;
        push = v && (t > 0) && (q.size() != DEPTH);
        bnd  = ((t % FRAME) == FRAME-1);
        @(posedge clk);
        exp_und = 1'b0;
        if (bnd) begin
            if (q.size() > 0) begin
                e     = q.pop_front();
                cur_l = e[31:16];
                cur_r = e[15:0];
            end else begin
                exp_und = 1'b1;
                if (!c_HOLD) begin
                    cur_l = '0;
                    cur_r = '0;
                end
            end
        end
        if (push)
            q.push_back({l, r});
        t++;
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input int n);
        reset        = 1'b1;
        sample_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_ready", sample_ready, 0);
            check("rst_level", fifo_level, 0);
            check("rst_lvl_m", fifo_level_m, 0);
            check("rst_clks",  {mclk, sclk, lrck}, 0);
            check("rst_dac",   {dac, dac_m}, 0);
            check("rst_und",   underrun, 0);
        end
        reset = 1'b0;
        t       = 0;
        q.delete();
        cur_l   = '0;
        cur_r   = '0;
        exp_und = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_l     = '0;
        sample_r     = '0;
        t            = 0;
        @(negedge clk);
        do_reset(3);

        // Single pair during frame 0, then starve the FIFO
        for (int i = 0; i < 5*FRAME; i++)
            cycle(i == 5, 16'h8001, 16'h7FFE);

        // Back-to-back burst of five pairs into an empty FIFO
        for (int i = 0; i < 5; i++)
            cycle(1'b1, (i == 0) ? 16'hA5A5 : 16'($urandom), 16'($urandom));
        check("burst_level", fifo_level, 4);
        check("burst_ready", sample_ready, 0);
        while ((t % FRAME) != 0)
            cycle(1'b0, '0, '0);
        check("pop_level", fifo_level, 3);
        cycle(1'b0, '0, '0);
        check("pop_ready", sample_ready, 1);
        for (int i = 0; i < 5*FRAME; i++)
            cycle(1'b0, '0, '0);

        // Random traffic at a per-frame random push rate
        for (int f = 0; f < 8; f++) begin
            int rate;
            rate = int'($urandom_range(300, 2500));
            for (int i = 0; i < FRAME; i++)
                cycle($urandom_range(0, rate-1) == 0, 16'($urandom), 16'($urandom));
        end

        // Reset mid-frame with three pairs queued
        do_reset(2);
        cycle(1'b0, '0, '0);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom));
        while (t < 20*BDIV)
            cycle(1'b0, '0, '0);
        check("pre_rst_level", fifo_level, 3);
        do_reset(1);
        cycle(1'b0, '0, '0);
        cycle(1'b1, 16'($urandom), 16'($urandom));
        while (t < FRAME-1)
            cycle(1'b0, '0, '0);
        check("first_pop_pre", fifo_level, 1);
        cycle(1'b0, '0, '0);
        check("first_pop_post", fifo_level, 0);
        for (int i = 0; i < 2*FRAME; i++)
            cycle(1'b0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
